// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit driving the HI/LO registers (shift-add / restoring divide).
// Optional MULTDIV_FAST_MULT_EN: MULT/MULTU resolve in one cycle through a combinational multiplier.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [DW-1:0]    acc_q, acc_d;

  logic             is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   r_sh, diff, sum;
  logic [DW-1:0]    prod;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v, input logic en);
    return en ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    is_signed = ~op[0];
    mag_a     = is_signed ? abs_w($signed(opA)) : opA;
    mag_b     = is_signed ? abs_w($signed(opB)) : opB;
    r_sh      = acc_q[DW-1:WIDTH-1];
    diff      = r_sh - {1'b0, opb_q};
    sum       = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    prod      = neg_dw(acc_q, qneg_q);

    case (state_q)
      IDLE: begin
        if (hiWrite) hi_d = writeData;
        if (loWrite) lo_d = writeData;
        if (start) begin
          // Work on magnitudes; signs are restored in FINISH.
          div_d   = op[1];
          qneg_d  = is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          rneg_d  = is_signed & opA[WIDTH-1];
          dz_d    = (opB == {WIDTH{1'b0}});
          opb_d   = op[1] ? mag_b : mag_a;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
`ifdef MULTDIV_FAST_MULT_EN
          if (!op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
            state_d = FINISH;
          end
`endif
        end
      end

      RUN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (div_q) begin
          // acc = {remainder, dividend/quotient}; quotient bits enter from the right.
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
      end

      FINISH: begin
        if (div_q) begin
          lo_d = dz_q ? {WIDTH{1'b1}} : neg_w(acc_q[WIDTH-1:0], qneg_q);
          hi_d = neg_w(acc_q[DW-1:WIDTH], rneg_q);
        end else begin
          hi_d = prod[DW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      acc_q   <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and latency queued at start, checked on done.
module tb_mult_div_unit;

`ifdef MULTDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
  localparam logic [1:0] SWB_OP = 2'b11;
  localparam logic [31:0] SWB_A = 32'd12;
`else
  localparam int MUL_LAT = 33;
  localparam logic [1:0] SWB_OP = 2'b01;
  localparam logic [31:0] SWB_A = 32'd3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0, opB = '0;
  logic        hiWrite = 1'b0, loWrite = 1'b0;
  logic [31:0] writeData = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, busy_len = 0, done_cnt = 0, next_id = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      p;
    logic [63:0] pu;
    case (o)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {eh, el} = p; end
      2'b01: begin pu = {32'd0, a} * {32'd0, b}; {eh, el} = pu; end
      2'b10: begin
        if (b == 32'd0) begin el = '1; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = '0; end
        else begin el = $signed(a) / $signed(b); eh = $signed(a) % $signed(b); end
      end
      default: begin
        if (b == 32'd0) begin el = '1; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Called at a negedge just before the edge that accepts start.
  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(o, a, b, e.hi, e.lo);
    e.id        = next_id;
    e.start_cyc = cyc + 1;
    e.lat       = o[1] ? 33 : MUL_LAT;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk({tag, "_timeout_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("op%0d_hi", mon_e.id), 64'(hi), 64'(mon_e.hi));
        chk($sformatf("op%0d_lo", mon_e.id), 64'(lo), 64'(mon_e.lo));
        chk($sformatf("op%0d_latency", mon_e.id), 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
        chk($sformatf("op%0d_busy_len", mon_e.id), 64'(busy_len), 64'(mon_e.lat));
      end
    end
    busy_len = busy ? busy_len + 1 : 0;
  end

  initial begin
    int dc;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst = 1'b0;

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle("multu_max");
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_idle("mult_neg");
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_idle("div_neg");
    launch(2'b11, 32'd5, 32'd0);                 wait_idle("divu_zero");
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle("div_ovf");
    launch(2'b10, 32'hFFFF_FFF9, 32'd0);         wait_idle("div_zero_neg");
    launch(2'b11, 32'd100, 32'd7);               wait_idle("divu_basic");

    // mthi / mtlo in IDLE
    @(negedge clk); hiWrite = 1'b1; writeData = 32'h1234_5678;
    @(negedge clk); hiWrite = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo_kept", 64'(lo), 64'd14);
    loWrite = 1'b1; writeData = 32'hCAFE_F00D;
    @(negedge clk); loWrite = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);

    // mtlo while busy is ignored
    launch(2'b11, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    loWrite = 1'b1; writeData = 32'hDEAD_BEEF;
    @(negedge clk); loWrite = 1'b0;
    chk("mtlo_busy_ignored", 64'(lo), 64'hCAFE_F00D);
    wait_idle("divu_after_mtlo");

    // start while busy is ignored
    launch(SWB_OP, SWB_A, 32'd4);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; opA = 32'd9; opB = 32'd9;
    @(negedge clk); start = 1'b0;
    wait_idle("start_while_busy");

    // mthi together with start: write lands, result later overwrites
    @(negedge clk);
    hiWrite = 1'b1; writeData = 32'h55AA_55AA;
    start = 1'b1; op = 2'b11; opA = 32'd1000; opB = 32'd33;
    push_exp(2'b11, 32'd1000, 32'd33);
    @(negedge clk); start = 1'b0; hiWrite = 1'b0;
    chk("mthi_with_start_hi", 64'(hi), 64'h55AA_55AA);
    wait_idle("divu_after_mthi");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 3) ra = 32'h8000_0000;
      launch(ro, ra, rb);
      wait_idle($sformatf("rand%0d", i));
    end

    // reset mid-operation aborts silently
    launch(2'b11, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));

    launch(2'b01, 32'd3, 32'd4); wait_idle("after_abort");
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS single-cycle datapath. Sits directly downstream of the register file and consumes its two read ports (rs, rt).
- Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. Supports mthi/mtlo writes.
- Exposes busy so control can stall the PC while an operation runs. HI/LO are read by the mfhi/mflo path.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH. Only 32 is supported for MIPS.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opA  input  32  rs value (multiplicand / dividend)
- opB  input  32  rt value (multiplier / divisor)
- hiWrite  input  1  mthi: HI <= writeData
- loWrite  input  1  mtlo: LO <= writeData
- writeData  input  32  data for mthi/mtlo
- busy  output  1  operation in progress
- done  output  1  single-cycle completion pulse
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: single clock domain. rst is synchronous active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, FSM=IDLE, internal accumulators=0.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN when start=1 at a rising edge.
  - That edge latches op, sign flags and operand magnitudes (signed ops take absolute values; unsigned ops take raw operands).
  - It also clears the iteration counter.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for WIDTH cycles. After the WIDTH-th step, go to FINISH.
- FINISH -> IDLE on the next edge. That edge:
  - applies the sign fix-up;
  - writes hi/lo;
  - sets done=1 for exactly one cycle.
- busy: 1 from the edge that accepts start until the edge that writes hi/lo (RUN and FINISH). done and the new hi/lo become visible in the same cycle that busy returns to 0.
- Latency: start accepted at edge N, results at edge N+WIDTH+1. That is 33 cycles for WIDTH=32.
- Multiply result: 64-bit product, hi = upper word, lo = lower word. For signed ops, negate the 64-bit product when sign(opA) XOR sign(opB).
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo = 32'hFFFFFFFF, hi = original opA. Same latency as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Falls out of the magnitude method with no special case.
- start while busy: ignored. The operation in progress is unaffected.
- hiWrite/loWrite while busy: ignored. Control must stall mthi/mtlo.
- hiWrite/loWrite in IDLE: hi/lo are updated at the next edge. If start is also high at that edge, the write is applied and the operation starts. The operation's result later overwrites hi/lo.
- hi and lo are not modified in any cycle other than FINISH or an mthi/mtlo write.
- rst mid-operation: at that edge return to IDLE, busy=0, hi=lo=0. done is not raised for the aborted operation.

Optional Feature:
- Macro: MULTDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU are computed combinationally with a 64-bit multiply. They go IDLE -> FINISH directly.
  - Results and done appear at edge N+1 for start at edge N; busy is high for one cycle.
  - DIV/DIVU are unchanged.
- Undefined: all operations use the iterative WIDTH-cycle path described above.

Test Plan:
- MULTU, opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 33 cycles after the start edge. busy is high for 33 cycles.
- MULT, opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). With MULTDIV_FAST_MULT_EN: same values, done 1 cycle after start.
- DIV, opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, opA=100, opB=7 -> lo=14, hi=2.
- DIVU, opA=5, opB=0 -> lo=0xFFFFFFFF, hi=5. DIV, opA=0x80000000, opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Reset and start-while-busy:
  - Start MULTU 3x4. Pulse start with different operands at cycle 5 -> ignored, result hi=0, lo=12.
  - Start again and assert rst at cycle 10 -> busy=0, hi=lo=0, no done pulse.
- mthi/mtlo:
  - In IDLE, hiWrite=1, writeData=0x12345678 -> hi=0x12345678 next cycle, lo unchanged.
  - loWrite during busy -> lo unchanged until FINISH.
